// File: rtl/mips_defs.sv
// Shared constants and types for the multi-cycle MIPS sequencer.
// Opcode/funct values, ALU op codes, state encodings, mux select codes,
// and the packed control-word bundle driven by the sequencer.
package mips_defs;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_FAULT  = 4'd14
  } state_e;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // Register write destination select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register write data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_opdecode.sv
// Opcode/funct decoder: picks the post-DECODE dispatch state and R-type ALU op.
// Latency: purely combinational, zero cycles.
// Backpressure: none; unsupported encodings map to the FAULT state.
module mc_opdecode
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_e     dispatch,
  output alu_op_e    r_alu_op
);

  // Map instruction class to its first execute state; default is FAULT
  always_comb begin
    dispatch = S_FAULT;
    r_alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: dispatch = S_EXEC;
          FN_SUB: begin
            dispatch = S_EXEC;
            r_alu_op = ALU_SUB;
          end
          FN_SLT: begin
            dispatch = S_EXEC;
            r_alu_op = ALU_SLT;
          end
          FN_JR:  dispatch = S_JR;
          default: ;
        endcase
      end
      OP_LW, OP_SW:     dispatch = S_MEMADR;
      OP_BEQ, OP_BNE:   dispatch = S_BRANCH;
      OP_J:             dispatch = S_JUMP;
      OP_JAL:           dispatch = S_JAL;
      OP_ADDI, OP_XORI: dispatch = S_IEXEC;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer driving datapath selects, enables and memory strobes.
// Latency: lw 5, sw/R-type/imm 4, branch/jump 3 cycles with memory ready at once.
// Backpressure: holds in FETCH/MEMRD/MEMWR until mem_ready; watchdog forces FAULT.
module multicycle_control
  import mips_defs::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [TMR_W-1:0] WD_LIMIT = TMR_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  state_e           dispatch;
  alu_op_e          r_alu_op;
  logic [TMR_W-1:0] wd_cnt_q, wd_cnt_d, wd_inc;
  logic             wait_st, wd_expire;
  ctrl_t            ctrl;

  mc_opdecode u_opdecode (
    .opcode   (opcode),
    .funct    (funct),
    .dispatch (dispatch),
    .r_alu_op (r_alu_op)
  );

  // wd_inc counts the current waiting cycle, so the limit fires on the
  // MEM_TIMEOUT-th cycle without ready; a ready in that cycle still wins.
  assign wait_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign wd_inc    = wd_cnt_q + TMR_W'(1);
  assign wd_expire = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (wd_inc == WD_LIMIT);

  // Watchdog next count: advance while stalled in a memory state, else clear
  always_comb begin
    wd_cnt_d = '0;
    if (wait_st && !mem_ready) wd_cnt_d = wd_inc;
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_cnt_q <= '0;
    else        wd_cnt_q <= wd_cnt_d;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; the unused encoding falls into FAULT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : (wd_expire ? S_FAULT : S_FETCH);
      S_DECODE: state_d = dispatch;
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : (wd_expire ? S_FAULT : S_MEMRD);
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : (wd_expire ? S_FAULT : S_MEMWR);
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_JAL:    state_d = S_FETCH;
      S_JR:     state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  // Control word decoded from state; everything held at zero during reset
  always_comb begin
    ctrl = '0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_en     = mem_ready;
        end
        S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_dst    = REGDST_RT;
          ctrl.mem_to_reg = M2R_MDR;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctrl.iord       = 1'b1;
          ctrl.mem_write  = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_RT;
          ctrl.alu_op    = r_alu_op;
        end
        S_RWB: begin
          ctrl.reg_dst    = REGDST_RD;
          ctrl.mem_to_reg = M2R_ALUOUT;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_IEXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        end
        S_IWB: begin
          ctrl.reg_dst    = REGDST_RT;
          ctrl.mem_to_reg = M2R_ALUOUT;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a  = 1'b1;
          ctrl.alu_src_b  = SRCB_RT;
          ctrl.alu_op     = ALU_SUB;
          ctrl.pc_source  = PCSRC_ALUOUT;
          ctrl.pc_en      = (opcode == OP_BNE) ? !alu_zero : alu_zero;
          ctrl.instr_done = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.pc_en      = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_JAL: begin
          // PC already holds PC+4 from FETCH, so it is the link value
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.pc_en      = 1'b1;
          ctrl.reg_dst    = REGDST_RA;
          ctrl.mem_to_reg = M2R_PC;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_JR: begin
          ctrl.pc_source  = PCSRC_RS;
          ctrl.pc_en      = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_FAULT: ctrl.illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign pc_source  = ctrl.pc_source;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign illegal    = ctrl.illegal;
  assign state      = reset ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a small watchdog limit.
// Each instruction pushes its per-cycle inputs and expected outputs to a queue,
// then the queue is drained one clock per entry and compared against the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
  logic       instr_done, illegal;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_en(pc_en),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic       done, illegal;
  } obs_t;

  typedef struct packed {
    logic rdy;
    logic zero;
    obs_t e;
  } step_t;

  obs_t  obs;
  step_t sq[$];
  string tq[$];
  int    checks = 0;
  int    failures = 0;

  assign obs = {state, pc_en, pc_source, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                instr_done, illegal};

  function automatic obs_t st(input logic [3:0] s);
    obs_t o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic obs_t fetch_e(input logic rdy);
    obs_t o = st(4'd0);
    o.mem_read = 1'b1;
    o.src_b    = 2'b01;
    o.pc_en    = rdy;
    o.ir_write = rdy;
    return o;
  endfunction

  function automatic obs_t decode_e();
    obs_t o = st(4'd1);
    o.src_b = 2'b11;
    return o;
  endfunction

  function automatic obs_t fault_e();
    obs_t o = st(4'd14);
    o.illegal = 1'b1;
    return o;
  endfunction

  task automatic push(input string tag, input logic rdy, input logic zero, input obs_t e);
    step_t s;
    s.rdy  = rdy;
    s.zero = zero;
    s.e    = e;
    sq.push_back(s);
    tq.push_back(tag);
  endtask

  task automatic push_fd(input string name);
    push({name, "_fetch"}, 1'b1, 1'b0, fetch_e(1'b1));
    push({name, "_decode"}, 1'b1, 1'b0, decode_e());
  endtask

  task automatic check(input string tag, input obs_t e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Drain the scoreboard: drive each step's inputs, compare, advance one clock
  task automatic run();
    step_t s;
    string t;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      t = tq.pop_front();
      mem_ready = s.rdy;
      alu_zero  = s.zero;
      #1;
      check(t, s.e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check(tag, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    obs_t e;
    reset = 1'b0; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", '0);
    reset = 1'b1;

    // lw: 0,1,2,3,4 then back to FETCH at the next instruction
    opcode = 6'h23;
    push_fd("lw");
    e = st(4'd2); e.src_a = 1'b1; e.src_b = 2'b10; push("lw_memadr", 1'b1, 1'b0, e);
    e = st(4'd3); e.iord = 1'b1; e.mem_read = 1'b1; push("lw_memrd", 1'b1, 1'b0, e);
    e = st(4'd4); e.mem_to_reg = 2'b01; e.reg_write = 1'b1; e.done = 1'b1;
    push("lw_memwb", 1'b1, 1'b0, e);
    run();

    // sw with one stall cycle in MEMWR
    opcode = 6'h2B;
    push_fd("sw");
    e = st(4'd2); e.src_a = 1'b1; e.src_b = 2'b10; push("sw_memadr", 1'b1, 1'b0, e);
    e = st(4'd5); e.iord = 1'b1; e.mem_write = 1'b1; push("sw_memwr_wait", 1'b0, 1'b0, e);
    e.done = 1'b1; push("sw_memwr_done", 1'b1, 1'b0, e);
    run();

    // R-type sub and slt
    opcode = 6'h00; funct = 6'h22;
    push_fd("sub");
    e = st(4'd6); e.src_a = 1'b1; e.alu_op = 3'd1; push("sub_exec", 1'b1, 1'b0, e);
    e = st(4'd7); e.reg_dst = 2'b01; e.reg_write = 1'b1; e.done = 1'b1; push("sub_rwb", 1'b1, 1'b0, e);
    run();
    funct = 6'h2A;
    push_fd("slt");
    e = st(4'd6); e.src_a = 1'b1; e.alu_op = 3'd3; push("slt_exec", 1'b1, 1'b0, e);
    e = st(4'd7); e.reg_dst = 2'b01; e.reg_write = 1'b1; e.done = 1'b1; push("slt_rwb", 1'b1, 1'b0, e);
    run();

    // addi and xori
    opcode = 6'h08;
    push_fd("addi");
    e = st(4'd8); e.src_a = 1'b1; e.src_b = 2'b10; push("addi_iexec", 1'b1, 1'b0, e);
    e = st(4'd9); e.reg_write = 1'b1; e.done = 1'b1; push("addi_iwb", 1'b1, 1'b0, e);
    run();
    opcode = 6'h0E;
    push_fd("xori");
    e = st(4'd8); e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 3'd2; push("xori_iexec", 1'b1, 1'b0, e);
    e = st(4'd9); e.reg_write = 1'b1; e.done = 1'b1; push("xori_iwb", 1'b1, 1'b0, e);
    run();

    // Branches: beq taken on zero, bne not taken on zero, bne taken on nonzero
    opcode = 6'h04;
    push_fd("beq_z1");
    e = st(4'd10); e.src_a = 1'b1; e.alu_op = 3'd1; e.pc_source = 2'b01; e.done = 1'b1;
    e.pc_en = 1'b1; push("beq_z1_branch", 1'b1, 1'b1, e);
    run();
    opcode = 6'h05;
    push_fd("bne_z1");
    e.pc_en = 1'b0; push("bne_z1_branch", 1'b1, 1'b1, e);
    push_fd("bne_z0");
    e.pc_en = 1'b1; push("bne_z0_branch", 1'b1, 1'b0, e);
    run();

    // Jumps
    opcode = 6'h02;
    push_fd("j");
    e = st(4'd11); e.pc_source = 2'b10; e.pc_en = 1'b1; e.done = 1'b1; push("j_jump", 1'b1, 1'b0, e);
    run();
    opcode = 6'h03;
    push_fd("jal");
    e = st(4'd12); e.pc_source = 2'b10; e.pc_en = 1'b1; e.reg_dst = 2'b10;
    e.mem_to_reg = 2'b10; e.reg_write = 1'b1; e.done = 1'b1; push("jal_jal", 1'b1, 1'b0, e);
    run();
    opcode = 6'h00; funct = 6'h08;
    push_fd("jr");
    e = st(4'd13); e.pc_source = 2'b11; e.pc_en = 1'b1; e.done = 1'b1; push("jr_jr", 1'b1, 1'b0, e);
    run();

    // Reset asserted mid-MEMRD, then FETCH stalls into the watchdog
    opcode = 6'h23;
    push_fd("lwrst");
    e = st(4'd2); e.src_a = 1'b1; e.src_b = 2'b10; push("lwrst_memadr", 1'b1, 1'b0, e);
    e = st(4'd3); e.iord = 1'b1; e.mem_read = 1'b1; push("lwrst_memrd", 1'b0, 1'b0, e);
    run();
    do_reset("rst_mid_memrd");
    for (int i = 0; i < 4; i++) push("fetch_stall", 1'b0, 1'b0, fetch_e(1'b0));
    push("fetch_timeout_fault", 1'b0, 1'b0, fault_e());
    push("fault_sticky_rdy", 1'b1, 1'b0, fault_e());
    run();
    do_reset("rst_from_fault");

    // Ready arrives in the limit cycle: access completes, no fault
    opcode = 6'h02;
    for (int i = 0; i < 3; i++) push("fetch_late_wait", 1'b0, 1'b0, fetch_e(1'b0));
    push("fetch_late_rdy", 1'b1, 1'b0, fetch_e(1'b1));
    push("late_decode", 1'b1, 1'b0, decode_e());
    e = st(4'd11); e.pc_source = 2'b10; e.pc_en = 1'b1; e.done = 1'b1; push("late_jump", 1'b1, 1'b0, e);
    run();

    // Watchdog in MEMRD
    opcode = 6'h23;
    push_fd("lwto");
    e = st(4'd2); e.src_a = 1'b1; e.src_b = 2'b10; push("lwto_memadr", 1'b1, 1'b0, e);
    e = st(4'd3); e.iord = 1'b1; e.mem_read = 1'b1;
    for (int i = 0; i < 4; i++) push("lwto_memrd_wait", 1'b0, 1'b0, e);
    push("lwto_fault", 1'b0, 1'b0, fault_e());
    run();
    do_reset("rst_after_memrd_to");

    // Illegal opcode: FAULT is sticky for 100 cycles regardless of inputs
    opcode = 6'h3F;
    push_fd("op3f");
    for (int i = 0; i < 100; i++) push("op3f_fault_hold", 1'(i % 2), 1'($urandom_range(1)), fault_e());
    run();
    do_reset("rst_after_op3f");

    // R-type with unsupported funct 0x00
    opcode = 6'h00; funct = 6'h00;
    push_fd("fn00");
    push("fn00_fault", 1'b1, 1'b0, fault_e());
    push("fn00_fault_hold", 1'b1, 1'b1, fault_e());
    run();
    do_reset("rst_final");
    push("final_fetch", 1'b1, 1'b0, fetch_e(1'b1));
    run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath: PC, shared instruction/data memory, IR, regfile, ALU, operand/result muxes.
- Walks each instruction through FETCH/DECODE/execute/memory/writeback states and drives every mux select, write enable and memory strobe.
- Waits on a memory ready handshake, with a watchdog timeout.
- Replaces per-opcode combinational control so one ALU and one memory port are shared across cycles.

Parameters:
- MEM_TIMEOUT, 255: max cycles waiting for mem_ready in any memory state before FAULT. 0 disables the watchdog.
- TMR_W, 8: watchdog counter width. Must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag, current cycle
- mem_ready  in  1  memory completes the access this cycle
- pc_en  out  1  PC load enable, already resolved for branches
- pc_source  out  2  00 ALU result, 01 ALUOut reg, 10 {PC[31:28],addr26,2'b00}, 11 rs
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_write  out  1  regfile write
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 imm32, 11 imm32<<2
- alu_op  out  3  ADD/SUB/XOR/SLT code from package
- state  out  4  current state encoding, debug only
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  high while in FAULT

Behaviour:
- Reset: while reset is low, the state register is FETCH and all outputs are forced to 0 combinationally, including during mid-instruction reset. FETCH outputs begin the first cycle after release.
- Outputs are decoded from state. pc_en, ir_write and instr_done are additionally gated by mem_ready or alu_zero as noted below. Default for every output is 0.
- Supported decode: R-type 0x00 with funct add 0x20, sub 0x22, slt 0x2A, jr 0x08. Opcodes lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03, addi 0x08, xori 0x0E.
- FETCH(0): iord=0, mem_read=1, src_a=0, src_b=01, ADD, pc_source=00. With mem_ready: ir_write=1 and pc_en=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE(1): src_a=0, src_b=11, ADD (branch target to ALUOut). Dispatch:
  - lw/sw -> MEMADR
  - add/sub/slt -> EXEC
  - jr -> JR
  - beq/bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - addi/xori -> IEXEC
  - anything else -> FAULT
- MEMADR(2): src_a=1, src_b=10, ADD. lw goes to MEMRD, sw goes to MEMWR.
- MEMRD(3): iord=1, mem_read=1. Wait for mem_ready, then go to MEMWB.
- MEMWB(4): reg_dst=00, mem_to_reg=01, reg_write=1, instr_done=1, then FETCH.
- MEMWR(5): iord=1, mem_write=1. Hold until mem_ready; that cycle instr_done=1 and next state is FETCH.
- EXEC(6): src_a=1, src_b=00, alu_op from funct, then RWB.
- RWB(7): reg_dst=01, reg_write=1, instr_done=1, then FETCH.
- IEXEC(8): src_a=1, src_b=10, ADD for addi, XOR for xori, then IWB.
- IWB(9): reg_dst=00, reg_write=1, instr_done=1, then FETCH.
- BRANCH(10): src_a=1, src_b=00, SUB, pc_source=01. pc_en = alu_zero for beq, !alu_zero for bne. instr_done=1, then FETCH.
- JUMP(11): pc_source=10, pc_en=1, instr_done=1, then FETCH.
- JAL(12): pc_source=10, pc_en=1, reg_dst=10, mem_to_reg=10, reg_write=1, instr_done=1, then FETCH. The link value is PC+4, because PC was already incremented in FETCH.
- JR(13): pc_source=11, pc_en=1, instr_done=1, then FETCH.
- FAULT(14): illegal=1, all strobes 0. Sticky until reset. Encoding 15 is unused and recovers to FAULT.
- Watchdog: counter clears on entry to FETCH, MEMRD or MEMWR, and increments each cycle mem_ready=0 in those states.
  - If the count equals MEM_TIMEOUT with mem_ready still 0: next state is FAULT.
  - If mem_ready=1 in that same cycle: the access completes normally; ready wins.
- Latency per instruction, with mem_ready=1 immediately:
  - lw: 5 cycles
  - sw, R-type, addi/xori: 4 cycles
  - beq/bne, j, jal, jr: 3 cycles

Decomposition:
- Package mips_defs holds:
  - opcode and funct constants
  - alu_op codes: ADD=0, SUB=1, XOR=2, SLT=3
  - state encodings 0–14
  - pc_source, reg_dst, mem_to_reg and alu_src_b select constants
- One sub-module, mc_opdecode: combinational opcode/funct to next-dispatch-state plus R-type alu_op. Shared by DECODE and EXEC.

Test Plan:
- Reset low mid-MEMRD -> all outputs 0 immediately. After release, state=0 and mem_read=1, iord=0.
- lw (0x23) with mem_ready=1 every cycle -> states 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=01, instr_done pulses exactly once.
- beq with alu_zero=1 -> pc_en=1, pc_source=01 in BRANCH. bne with alu_zero=1 -> pc_en=0. Both retire after 3 cycles.
- jal (0x03) -> JAL cycle: reg_dst=10, mem_to_reg=10, reg_write=1, pc_en=1, pc_source=10.
- FETCH with mem_ready held 0 and MEM_TIMEOUT=4 -> FAULT after 4 wait cycles, illegal=1, no pc_en/ir_write. Repeat with mem_ready=1 on the 4th cycle -> DECODE, not FAULT.
- opcode 0x3F, or R-type with funct 0x00 -> DECODE goes to FAULT. FAULT holds for 100 cycles until reset.
